sc_neuron_sequencer: RTL

Run controller for the stochastic-computing APC neuron (`N` lanes, `S`-bit saturating output FSM). It takes binary inputs and weights, generates per-lane bitstreams with two LFSR SNGs, and drives the neuron for a programmable stream length. It also compensates the neuron's 2-cycle pipeline, counts ones on the neuron's output stream, and returns a binary result with a start/done handshake. It sits between the layer controller and one neuron instance; the neuron is reset and fed only through this block.

---
 rtl/sc_neuron_sequencer_if.sv | 50 +++++
 rtl/sc_neuron_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sc_neuron_sequencer_if.sv
// sc_neuron_sequencer_if
//   Start/done handshake and operand bus between the layer controller
//   (master) and the stochastic-computing neuron sequencer (slave).
//   Signals:
//     start  - request a run (master -> slave)
//     len    - stream length in cycles, LEN_W bits
//     x_bin  - N packed B-bit input operands, lane i at [i*B +: B]
//     w_bin  - N packed B-bit weights, same packing
//     busy   - sequencer not idle (slave -> master)
//     done   - one-cycle completion pulse
//     result - ones counted on the neuron output, LEN_W bits
//     abort  - cancel a run; exists only when SC_SEQ_ABORT_EN is defined
interface sc_neuron_sequencer_if #(
  parameter int K     = 3,
  parameter int B     = 8,
  parameter int LEN_W = 10
);
  localparam int N = 2 ** K;

  logic             start;
  logic [LEN_W-1:0] len;
  logic [N*B-1:0]   x_bin;
  logic [N*B-1:0]   w_bin;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] result;
`ifdef SC_SEQ_ABORT_EN
  logic             abort;

  modport master (
    output start, len, x_bin, w_bin, abort,
    input  busy, done, result
  );

  modport slave (
    input  start, len, x_bin, w_bin, abort,
    output busy, done, result
  );
`else
  modport master (
    output start, len, x_bin, w_bin,
    input  busy, done, result
  );

  modport slave (
    input  start, len, x_bin, w_bin,
    output busy, done, result
  );
`endif
endinterface

// File: rtl/sc_neuron_sequencer.sv
// sc_neuron_sequencer
//   Run controller for an N-lane stochastic-computing APC neuron. Latches
//   binary operands on start, generates per-lane bitstreams from two 8-bit
//   LFSR SNGs for len cycles, waits out the neuron's 2-cycle pipeline and
//   counts ones on the neuron output, returning the count with done.
//   Optional feature macro: SC_SEQ_ABORT_EN (adds bus.abort).
//   Ports:
//     clk        - clock
//     reset      - asynchronous, active-high
//     bus        - sc_neuron_sequencer_if.slave (start/len/x_bin/w_bin in,
//                  busy/done/result out, abort in when enabled)
//     neu_rst    - registered reset to the neuron
//     neu_din    - neuron data lanes
//     neu_weight - neuron weight lanes
//     neu_dout   - neuron output bit
module sc_neuron_sequencer #(
  parameter int K     = 3,
  parameter int N     = 2 ** K,
  parameter int B     = 8,
  parameter int LEN_W = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  sc_neuron_sequencer_if.slave    bus,
  output logic                    neu_rst,
  output logic [N-1:0]            neu_din,
  output logic [N-1:0]            neu_weight,
  input  logic                    neu_dout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [7:0]   SEED_X  = 8'h01;
  localparam logic [7:0]   SEED_W  = 8'hA5;
  // Lower half of the lanes set: the neuron sees a count of N/2 and holds.
  localparam logic [N-1:0] NEUTRAL = {{(N/2){1'b0}}, {(N/2){1'b1}}};

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [N*B-1:0]   x_q, x_d;
  logic [N*B-1:0]   w_q, w_d;
  logic [7:0]       lfsr_x_q, lfsr_x_d;
  logic [7:0]       lfsr_w_q, lfsr_w_d;
  logic [LEN_W:0]   k_q, k_d;
  logic [LEN_W-1:0] ones_q, ones_d;
  logic [LEN_W-1:0] result_q, result_d;
  logic             neu_rst_q, neu_rst_d;
  logic             abort_w;

`ifdef SC_SEQ_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned r);
    logic [15:0] t;
    t = {v, v} << r;
    return t[15:8];
  endfunction

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    x_d       = x_q;
    w_d       = w_q;
    lfsr_x_d  = lfsr_x_q;
    lfsr_w_d  = lfsr_w_q;
    k_d       = k_q;
    ones_d    = ones_q;
    result_d  = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          len_d = bus.len;
          x_d   = bus.x_bin;
          w_d   = bus.w_bin;
          if (bus.len == '0) begin
            state_d  = ST_DONE;
            result_d = '0;
          end else begin
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        lfsr_x_d = SEED_X;
        lfsr_w_d = SEED_W;
        k_d      = '0;
        ones_d   = '0;
        state_d  = ST_STREAM;
      end
      ST_STREAM: begin
        lfsr_x_d = lfsr_step(lfsr_x_q);
        lfsr_w_d = lfsr_step(lfsr_w_q);
        k_d      = k_q + 1'b1;
        // neu_dout lags input by 2 cycles: samples k>=2 belong to input k-2.
        if (neu_dout && (k_q >= (LEN_W+1)'(2))) ones_d = ones_q + 1'b1;
        if (k_q == {1'b0, len_q} - 1'b1) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        k_d = k_q + 1'b1;
        if (neu_dout && (k_q >= (LEN_W+1)'(2))) ones_d = ones_q + 1'b1;
        if (k_q == {1'b0, len_q} + 1'b1) begin
          state_d  = ST_DONE;
          // Load on entry so result is already valid while done is high.
          result_d = ones_d;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    neu_rst_d = (state_d == ST_CLEAR);

    if (abort_w && ((state_q == ST_CLEAR) || (state_q == ST_STREAM) ||
                    (state_q == ST_DRAIN))) begin
      state_d   = ST_IDLE;
      result_d  = result_q;
      neu_rst_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      x_q       <= '0;
      w_q       <= '0;
      lfsr_x_q  <= SEED_X;
      lfsr_w_q  <= SEED_W;
      k_q       <= '0;
      ones_q    <= '0;
      result_q  <= '0;
      neu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      x_q       <= x_d;
      w_q       <= w_d;
      lfsr_x_q  <= lfsr_x_d;
      lfsr_w_q  <= lfsr_w_d;
      k_q       <= k_d;
      ones_q    <= ones_d;
      result_q  <= result_d;
      neu_rst_q <= neu_rst_d;
    end
  end

  always_comb begin
    neu_din    = NEUTRAL;
    neu_weight = NEUTRAL;
    if (state_q == ST_STREAM) begin
      for (int unsigned i = 0; i < N; i++) begin
        neu_din[i]    = x_q[i*B +: B] > rotl8(lfsr_x_q, i % 8);
        neu_weight[i] = w_q[i*B +: B] > rotl8(lfsr_w_q, i % 8);
      end
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign neu_rst    = neu_rst_q;

endmodule
